demux_regbank8x4: RTL



---
 rtl/demux_regbank8x4_pkg.sv | 19 +
 rtl/demux_regbank8x4_demux1to8.sv | 41 ++++
 rtl/demux_regbank8x4.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/demux_regbank8x4_pkg.sv
// ---------------------------------------------------------------------------
// demux_regbank8x4_pkg
// Shared definitions for the 8x4 demultiplexed register bank:
//   - bank geometry (DEPTH entries of WIDTH bits, PTR_W-bit index)
//   - load-sequencer state encoding (IDLE=0, LOAD=1, DONE=2)
// ---------------------------------------------------------------------------
package demux_regbank8x4_pkg;

    localparam int DEPTH = 8;
    localparam int WIDTH = 4;
    localparam int PTR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : demux_regbank8x4_pkg

// File: rtl/demux_regbank8x4_demux1to8.sv
// ---------------------------------------------------------------------------
// demux1to8
// 3-to-8 one-hot decoder with enable; the write-side inverse of the 8-to-1
// read selector. Produces one write strobe per bank entry.
// Ports:
//   en_i    in  1  write enable; all strobes low when 0
//   sel_i   in  3  entry index
//   strb_o  out 8  one-hot write strobes (strb_o[k] = en_i & (sel_i == k))
// ---------------------------------------------------------------------------
module demux1to8
    import demux_regbank8x4_pkg::*;
(
    input  logic             en_i,
    input  logic [PTR_W-1:0] sel_i,
    output logic [DEPTH-1:0] strb_o
);

    logic s0_s;
    logic s1_s;
    logic s2_s;
    logic n0_s;
    logic n1_s;
    logic n2_s;

    assign s0_s = sel_i[0];
    assign s1_s = sel_i[1];
    assign s2_s = sel_i[2];
    assign n0_s = ~sel_i[0];
    assign n1_s = ~sel_i[1];
    assign n2_s = ~sel_i[2];

    assign strb_o[0] = en_i & n2_s & n1_s & n0_s;
    assign strb_o[1] = en_i & n2_s & n1_s & s0_s;
    assign strb_o[2] = en_i & n2_s & s1_s & n0_s;
    assign strb_o[3] = en_i & n2_s & s1_s & s0_s;
    assign strb_o[4] = en_i & s2_s & n1_s & n0_s;
    assign strb_o[5] = en_i & s2_s & n1_s & s0_s;
    assign strb_o[6] = en_i & s2_s & s1_s & n0_s;
    assign strb_o[7] = en_i & s2_s & s1_s & s0_s;

endmodule : demux1to8

// File: rtl/demux_regbank8x4.sv
// ---------------------------------------------------------------------------
// demux_regbank8x4
// Eight-entry, 4-bit register bank written through a 1-to-8 demultiplexer.
// IDLE: addressed writes (wr_en/select). LOAD: sequential writes at an
// internal pointer on in_valid. DONE: one-cycle completion pulse.
// Ports:
//   clk          in  1  rising-edge clock
//   reset_n      in  1  asynchronous active-low reset
//   clear        in  1  synchronous clear of bank/pointer/state, top priority
//   in           in  4  write data
//   wr_en        in  1  addressed write strobe (IDLE only)
//   select       in  3  addressed write index
//   load_start   in  1  enter/restart sequential load (ignored in DONE)
//   in_valid     in  1  sequential-load data strobe (LOAD only)
//   out_7..out_0 out 4  registered entry contents
//   ptr          out 3  load pointer
//   busy         out 1  high while in LOAD
//   done         out 1  one-cycle pulse in DONE
// ---------------------------------------------------------------------------
module demux_regbank8x4
    import demux_regbank8x4_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] in,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] select,
    input  logic             load_start,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_7,
    output logic [WIDTH-1:0] out_6,
    output logic [WIDTH-1:0] out_5,
    output logic [WIDTH-1:0] out_4,
    output logic [WIDTH-1:0] out_3,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_0,
    output logic [PTR_W-1:0] ptr,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             busy_q;
    logic             done_q;
    logic             clr_s;
    logic             we_s;
    logic [PTR_W-1:0] waddr_s;
    logic [DEPTH-1:0] strb_s;
    logic [WIDTH-1:0] bank_q [DEPTH];

    // Sequencer next-state, pointer update and write-port steering
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_s   = 1'b0;
        we_s    = 1'b0;
        waddr_s = select;
        if (clear) begin
            clr_s   = 1'b1;
            state_d = ST_IDLE;
            ptr_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_d = ST_LOAD;
                        ptr_d   = 3'd0;
                    end else if (wr_en) begin
                        we_s    = 1'b1;
                        waddr_s = select;
                    end else begin
                        we_s    = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        ptr_d   = 3'd0;
                    end else if (in_valid) begin
                        we_s    = 1'b1;
                        waddr_s = ptr_q;
                        // 3-bit increment wraps 7 -> 0 on the final write
                        ptr_d   = ptr_q + 3'd1;
                        if (ptr_q == 3'd7) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        ptr_d   = ptr_q;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    ptr_d   = 3'd0;
                end
            endcase
        end
    end

    demux1to8 u_demux (
        .en_i   (we_s),
        .sel_i  (waddr_s),
        .strb_o (strb_s)
    );

    // State, pointer and status flags; flags come from the next state so they
    // are flop outputs aligned with the state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= (state_d == ST_LOAD);
            done_q  <= (state_d == ST_DONE);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        // One 4-bit entry with clear and per-entry write strobe
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                bank_q[k] <= 4'h0;
            end else if (clr_s) begin
                bank_q[k] <= 4'h0;
            end else if (strb_s[k]) begin
                bank_q[k] <= in;
            end else begin
                bank_q[k] <= bank_q[k];
            end
        end
    end

    assign out_0 = bank_q[0];
    assign out_1 = bank_q[1];
    assign out_2 = bank_q[2];
    assign out_3 = bank_q[3];
    assign out_4 = bank_q[4];
    assign out_5 = bank_q[5];
    assign out_6 = bank_q[6];
    assign out_7 = bank_q[7];
    assign ptr   = ptr_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule : demux_regbank8x4
